// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: decodes a multiplexed 8-digit 7-segment scan into a judge code; optional SEG_DEC_CONFIRM_EN requires two agreeing frames
module seg_scan_decoder #(
  parameter int SETTLE = 4,
  parameter int TO_W   = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_seg,
  input  logic [7:0] i_com,
  output logic [1:0] o_judge,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_stall
);
  localparam logic [63:0] P_PERFECT = 64'h0C06AF0E064607FF;
  localparam logic [63:0] P_NORMAL  = 64'hABA3AFAB0887FFFF;
  localparam logic [63:0] P_MISS    = 64'hFFFFABF91212FFFF;
  localparam logic [63:0] P_IDLE    = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [3:0]  L_SET     = SETTLE[3:0];
  logic [7:0]      r_seg, r_com, r_com_d, r_seen;
  logic [7:0]      r_buf [8];
  logic [3:0]      r_cnt;
  logic [TO_W-1:0] r_to;
  logic            r_done, r_ok;
  logic [1:0]      r_code;
`ifdef SEG_DEC_CONFIRM_EN
  logic            r_cand_v;
  logic [1:0]      r_cand;
`endif
  logic            w_chg, w_hit, w_one, w_blank, w_ill_hit, w_cap, w_full, w_sat, w_match;
  logic [3:0]      w_cnt;
  logic [7:0]      w_zero;
  logic [2:0]      w_idx;
  logic [63:0]     w_frame;
  logic [1:0]      w_code;
  // dwell tracking, com legality and frame matching
  always_comb begin
    w_chg     = r_com != r_com_d;
    w_cnt     = w_chg ? 4'd1 : (r_cnt == 4'hF ? r_cnt : r_cnt + 4'd1);
    w_hit     = (w_cnt == L_SET) && (w_chg || r_cnt != L_SET);
    w_zero    = ~r_com;
    w_blank   = r_com == 8'hFF;
    w_one     = !w_blank && ((w_zero & (w_zero - 8'd1)) == 8'd0);
    w_ill_hit = w_hit && !w_blank && !w_one;
    w_cap     = w_hit && w_one;
    w_full    = r_seen == 8'hFF;
    w_sat     = &r_to;
    w_idx     = 3'd0;
    for (int k = 0; k < 8; k++) if (!r_com[k]) w_idx = k[2:0];
    for (int k = 0; k < 8; k++) w_frame[k*8 +: 8] = r_buf[k];
    w_code    = w_frame == P_PERFECT ? 2'b11 : w_frame == P_NORMAL ? 2'b10 : w_frame == P_MISS ? 2'b01 : 2'b00;
    w_match   = w_frame == P_PERFECT || w_frame == P_NORMAL || w_frame == P_MISS || w_frame == P_IDLE;
  end
  assign o_stall = w_sat;
  // input registers, settle counter and saturating stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg   <= 8'hFF;
      r_com   <= 8'hFF;
      r_com_d <= 8'hFF;
      r_cnt   <= 4'd0;
      r_to    <= '0;
    end else begin
      r_seg   <= i_seg;
      r_com   <= i_com;
      r_com_d <= r_com;
      r_cnt   <= w_cnt;
      r_to    <= w_chg ? '0 : (w_sat ? r_to : r_to + 1'b1);
    end
  end
  // digit capture into the buffer and seen-mask bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seen <= 8'h00;
      for (int k = 0; k < 8; k++) r_buf[k] <= 8'hFF;
    end else begin
      if (w_cap) r_buf[w_idx] <= r_seg;
      if (w_ill_hit || w_sat) r_seen <= 8'h00;
      else if (w_cap) r_seen <= (w_full ? 8'h00 : r_seen) | (8'h01 << w_idx);
      else if (w_full) r_seen <= 8'h00;
    end
  end
  // frame result pipeline; an illegal com wins over a result landing on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done      <= 1'b0;
      r_ok        <= 1'b0;
      r_code      <= 2'b00;
      o_judge     <= 2'b00;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef SEG_DEC_CONFIRM_EN
      r_cand_v    <= 1'b0;
      r_cand      <= 2'b00;
`endif
    end else begin
      r_done      <= w_full && !w_ill_hit;
      r_ok        <= w_match;
      r_code      <= w_code;
      o_valid     <= 1'b0;
      o_frame_err <= w_ill_hit;
      if (!w_ill_hit && r_done) begin
        if (!r_ok) begin
          o_frame_err <= 1'b1;
`ifdef SEG_DEC_CONFIRM_EN
          r_cand_v    <= 1'b0;
`endif
        end else begin
`ifdef SEG_DEC_CONFIRM_EN
          if (r_code == o_judge) r_cand_v <= 1'b0;
          else if (r_cand_v && r_cand == r_code) begin
            o_judge  <= r_code;
            o_valid  <= 1'b1;
            r_cand_v <= 1'b0;
          end else begin
            r_cand   <= r_code;
            r_cand_v <= 1'b1;
          end
`else
          o_judge <= r_code;
          o_valid <= 1'b1;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed table-driven check of seg_scan_decoder (SETTLE=4, TO_W=6)
module tb_seg_scan_decoder;
  localparam logic [63:0] PF = 64'h0C06AF0E064607FF;
  localparam logic [63:0] NM = 64'hABA3AFAB0887FFFF;
  localparam logic [63:0] MS = 64'hFFFFABF91212FFFF;
  localparam logic [63:0] ID = 64'hFFFFFFFFFFFFFFFF;
  typedef struct {
    logic [63:0] frame;
    logic [1:0]  judge;
    int          nv;
    int          ne;
  } vec_t;
  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] i_seg = 8'hFF, i_com = 8'hFF;
  logic [1:0] o_judge;
  logic       o_valid, o_frame_err, o_stall;
  int vecs = 0, errs = 0, n_valid = 0, n_err = 0, v0, e0;
  vec_t tbl [8];
  seg_scan_decoder #(.SETTLE(4), .TO_W(6)) dut (
    .clk(clk), .rst(rst), .i_seg(i_seg), .i_com(i_com),
    .o_judge(o_judge), .o_valid(o_valid), .o_frame_err(o_frame_err), .o_stall(o_stall)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (o_valid) n_valid++;
    if (o_frame_err) n_err++;
    if (o_valid && o_frame_err) begin
      errs++;
      $display("FAIL valid_and_err: both asserted at %0t", $time);
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic scan(input logic [63:0] f, input int hi, input int lo);
    for (int d = hi; d >= lo; d--) begin
      @(negedge clk);
      i_com = ~(8'h01 << d);
      i_seg = f[d*8 +: 8];
      repeat (15) @(negedge clk);
    end
  endtask
  task automatic blank(input int n);
    @(negedge clk);
    i_com = 8'hFF;
    i_seg = 8'hFF;
    repeat (n - 1) @(negedge clk);
  endtask
  task automatic mark;
    v0 = n_valid;
    e0 = n_err;
  endtask
  initial begin
    tbl[0] = '{NM, 2'b10, 1, 0};
    tbl[1] = '{MS, 2'b01, 1, 0};
    tbl[2] = '{ID, 2'b00, 1, 0};
    tbl[3] = '{PF, 2'b11, 1, 0};
    tbl[4] = '{64'h0C06AF00064607FF, 2'b11, 0, 1};
    tbl[5] = '{PF, 2'b11, 1, 0};
    tbl[6] = '{64'h0, 2'b11, 0, 1};
    tbl[7] = '{NM, 2'b10, 1, 0};
    repeat (3) @(negedge clk);
    chk("reset_judge", o_judge, 0);
    chk("reset_valid", o_valid, 0);
    chk("reset_err", o_frame_err, 0);
    chk("reset_stall", o_stall, 0);
    rst = 1'b0;
    blank(3);
    mark();
    scan(PF, 7, 1);
    @(negedge clk);
    i_com = 8'hFE;
    i_seg = 8'hFF;
    repeat (6) @(negedge clk);
    chk("pf_valid_early", o_valid, 0);
    @(negedge clk);
    chk("pf_valid_pulse", o_valid, 1);
    chk("pf_judge", o_judge, 3);
    @(negedge clk);
    chk("pf_valid_once", o_valid, 0);
    repeat (8) @(negedge clk);
    chk("pf_err_none", n_err - e0, 0);
    blank(4);
    for (int i = 0; i < 8; i++) begin
      mark();
      scan(tbl[i].frame, 7, 0);
      blank(4);
      chk($sformatf("tbl%0d_judge", i), o_judge, tbl[i].judge);
      chk($sformatf("tbl%0d_valid", i), n_valid - v0, tbl[i].nv);
      chk($sformatf("tbl%0d_err", i), n_err - e0, tbl[i].ne);
    end
    @(negedge clk);
    i_com = 8'hFE;
    i_seg = 8'hFF;
    repeat (59) @(negedge clk);
    chk("stall_early", o_stall, 0);
    repeat (6) @(negedge clk);
    chk("stall_set", o_stall, 1);
    @(negedge clk);
    i_com = 8'hFF;
    repeat (2) @(negedge clk);
    chk("stall_clear", o_stall, 0);
    mark();
    scan(PF, 7, 1);
    chk("stall_seen_cleared", n_valid - v0, 0);
    scan(PF, 0, 0);
    blank(4);
    chk("stall_then_frame", n_valid - v0, 1);
    scan(MS, 7, 0);
    blank(4);
    chk("miss_judge", o_judge, 1);
    mark();
    scan(PF, 7, 4);
    @(negedge clk);
    i_com = 8'hF3;
    repeat (19) @(negedge clk);
    chk("ill_err", n_err - e0, 1);
    chk("ill_judge_hold", o_judge, 1);
    chk("ill_valid", n_valid - v0, 0);
    scan(PF, 3, 0);
    chk("ill_seen_cleared", n_valid - v0, 0);
    scan(PF, 7, 4);
    blank(4);
    chk("ill_recover_judge", o_judge, 3);
    chk("ill_recover_valid", n_valid - v0, 1);
    scan(PF, 7, 3);
    #3 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_judge", o_judge, 0);
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_err", o_frame_err, 0);
    chk("mid_rst_stall", o_stall, 0);
    i_com = 8'hFF;
    i_seg = 8'hFF;
    @(negedge clk);
    rst = 1'b0;
    mark();
    scan(ID, 2, 0);
    chk("rst_discard_valid", n_valid - v0, 0);
    chk("rst_discard_err", n_err - e0, 0);
    scan(ID, 7, 3);
    blank(4);
    chk("rst_idle_judge", o_judge, 0);
    chk("rst_idle_valid", n_valid - v0, 1);
    chk("rst_idle_err", n_err - e0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
